// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with memory/ALU write-back select and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports and mask their hazards.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_add1,
    input  logic [ADDR_W-1:0] rd_add2,
    output logic [XLEN-1:0]   rd_data1,
    output logic [XLEN-1:0]   rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_add,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              memtoreg,
    input  logic [XLEN-1:0]   meminp,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_add,
    output logic              hazard1,
    output logic              hazard2,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int NREGS = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [CNT_W-1:0] pend_cnt_q;
    logic [CNT_W-1:0] pend_cnt_d;
    logic [XLEN-1:0]  wsel;
    logic             wr_live;
    logic             iss_live;

    assign wsel     = memtoreg ? meminp : wr_data;
    assign wr_live  = wr_en && (wr_add != '0);
    assign iss_live = iss_en && (iss_add != '0);
    assign pend_cnt = pend_cnt_q;

    always_comb begin
        regs_d = regs_q;
        if (wr_live) begin
            regs_d[wr_add] = wsel;
        end
        regs_d[0] = '0;
    end

    always_comb begin
        pending_d = pending_q;
        if (wr_live) begin
            pending_d[wr_add] = 1'b0;
        end
        // Issue is applied after the clear: a same-cycle reissue belongs to a younger instruction.
        if (iss_live) begin
            pending_d[iss_add] = 1'b1;
        end
        pending_d[0] = 1'b0;
        pend_cnt_d = '0;
        for (int i = 1; i < NREGS; i++) begin
            pend_cnt_d = pend_cnt_d + CNT_W'(pending_d[i]);
        end
    end

    always_comb begin
        rd_data1 = (rd_add1 == '0) ? '0 : regs_q[rd_add1];
        rd_data2 = (rd_add2 == '0) ? '0 : regs_q[rd_add2];
        hazard1  = (rd_add1 != '0) && pending_q[rd_add1];
        hazard2  = (rd_add2 != '0) && pending_q[rd_add2];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (wr_add == rd_add1)) begin
            rd_data1 = wsel;
            hazard1  = 1'b0;
        end
        if (wr_live && (wr_add == rd_add2)) begin
            rd_data2 = wsel;
            hazard2  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            pending_q  <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end
endmodule
